// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit-type encoding, head-flit field packing and
// the request/response structs carried by router_if.
package ravenoc_pkg;

  localparam int X_WIDTH       = 2;
  localparam int Y_WIDTH       = 2;
  localparam int NUM_VC        = 2;
  localparam int VC_WIDTH      = 1;
  localparam int PAYLOAD_WIDTH = 32;
  localparam int PKT_LEN_FIELD = 16;
  localparam int FLIT_WIDTH    = 2 + PAYLOAD_WIDTH;
  localparam int HEAD_RSVD_W   = PAYLOAD_WIDTH - 2*X_WIDTH - 2*Y_WIDTH - PKT_LEN_FIELD;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'd0,
    BODY_FLIT      = 2'd1,
    TAIL_FLIT      = 2'd2,
    HEAD_TAIL_FLIT = 2'd3
  } flit_type_t;

  typedef struct packed {
    logic [X_WIDTH-1:0]       x_dest;
    logic [Y_WIDTH-1:0]       y_dest;
    logic [X_WIDTH-1:0]       x_src;
    logic [Y_WIDTH-1:0]       y_src;
    logic [PKT_LEN_FIELD-1:0] pkt_len;
    logic [HEAD_RSVD_W-1:0]   rsvd;
  } s_head_t;

  typedef struct packed {
    flit_type_t               ftype;
    logic [PAYLOAD_WIDTH-1:0] data;
  } s_flit_t;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] fdata;
    logic [VC_WIDTH-1:0]   vc_id;
    logic                  valid;
  } s_flit_req_t;

  typedef struct packed {
    logic [NUM_VC-1:0] ready;
  } s_flit_resp_t;

  function automatic logic [PAYLOAD_WIDTH-1:0] pack_head(
    input logic [X_WIDTH-1:0]       dx,
    input logic [Y_WIDTH-1:0]       dy,
    input logic [X_WIDTH-1:0]       sx,
    input logic [Y_WIDTH-1:0]       sy,
    input logic [PKT_LEN_FIELD-1:0] len
  );
    s_head_t h;
    h.x_dest  = dx;
    h.y_dest  = dy;
    h.x_src   = sx;
    h.y_src   = sy;
    h.pkt_len = len;
    h.rsvd    = '0;
    return h;
  endfunction

endpackage

// File: rtl/ravenoc_flit_gen_if.sv
// Router link interface: flit request towards the router, per-VC ready back.
interface router_if;
  import ravenoc_pkg::*;

  s_flit_req_t  req;
  s_flit_resp_t resp;

  modport send_flit (output req, input resp);
  modport recv_flit (input req, output resp);
endinterface

// File: rtl/ravenoc_flit_gen.sv
// Packet generator: emits head + pkt_len body flits on one VC per start pulse.
// Optional stall statistics counter enabled by RAVENOC_FLIT_GEN_STATS_EN.
module ravenoc_flit_gen
  import ravenoc_pkg::*;
#(
  parameter  int ROUTER_X_ID = 0,
  parameter  int ROUTER_Y_ID = 0,
  parameter  int MAX_PKT_LEN = 255,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                clk_noc,
  input  logic                arst_noc,
  router_if.send_flit         send,
  input  logic                start,
  input  logic [X_WIDTH-1:0]  dest_x,
  input  logic [Y_WIDTH-1:0]  dest_y,
  input  logic [VC_WIDTH-1:0] vc_sel,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic [31:0]         stall_cnt
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, DONE} state_t;

  state_t              state_q, state_d;
  logic [X_WIDTH-1:0]  dest_x_q, dest_x_d;
  logic [Y_WIDTH-1:0]  dest_y_q, dest_y_d;
  logic [VC_WIDTH-1:0] vc_q, vc_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [31:0]         seed_q, seed_d;

  s_flit_req_t req;
  s_flit_t     flit;
  logic        ready_sel;

  assign ready_sel = send.resp.ready[vc_q];
  assign send.req  = req;

  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      state_q  <= IDLE;
      dest_x_q <= '0;
      dest_y_q <= '0;
      vc_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      seed_q   <= '0;
    end else begin
      state_q  <= state_d;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
      vc_q     <= vc_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      seed_q   <= seed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    vc_d     = vc_q;
    len_d    = len_q;
    idx_d    = idx_q;
    seed_d   = seed_q;
    req      = '0;
    flit     = '0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dest_x_d = dest_x;
          dest_y_d = dest_y;
          vc_d     = vc_sel;
          len_d    = pkt_len;
          seed_d   = seed;
          state_d  = HEAD;
        end
      end
      HEAD: begin
        busy       = 1'b1;
        flit.ftype = (len_q == '0) ? HEAD_TAIL_FLIT : HEAD_FLIT;
        flit.data  = pack_head(dest_x_q, dest_y_q, X_WIDTH'(ROUTER_X_ID),
                               Y_WIDTH'(ROUTER_Y_ID), PKT_LEN_FIELD'(len_q));
        req.valid  = 1'b1;
        req.vc_id  = vc_q;
        req.fdata  = flit;
        if (ready_sel) begin
          idx_d   = '0;
          state_d = (len_q == '0) ? DONE : BODY;
        end
      end
      BODY: begin
        busy       = 1'b1;
        flit.ftype = (idx_q == len_q - LEN_W'(1)) ? TAIL_FLIT : BODY_FLIT;
        flit.data  = seed_q + PAYLOAD_WIDTH'(idx_q);
        req.valid  = 1'b1;
        req.vc_id  = vc_q;
        req.fdata  = flit;
        if (ready_sel) begin
          if (idx_q == len_q - LEN_W'(1)) state_d = DONE;
          else                            idx_d   = idx_q + LEN_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RAVENOC_FLIT_GEN_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Saturating: holds at all-ones instead of wrapping back to zero.
  always_comb begin
    stall_d = stall_q;
    if (req.valid && !ready_sel && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_noc) begin
    if (arst_noc) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ravenoc_flit_gen.sv
// Directed self-checking bench for ravenoc_flit_gen (ROUTER_X_ID=1, ROUTER_Y_ID=3).
module tb_ravenoc_flit_gen;
  import ravenoc_pkg::*;

  logic        clk_noc = 1'b0;
  logic        arst_noc;
  logic        start;
  logic [1:0]  dest_x, dest_y;
  logic [0:0]  vc_sel;
  logic [7:0]  pkt_len;
  logic [31:0] seed;
  logic        busy, done;
  logic [31:0] stall_cnt;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned exp_stall = 0;

  router_if rif ();

  ravenoc_flit_gen #(
    .ROUTER_X_ID (1),
    .ROUTER_Y_ID (3),
    .MAX_PKT_LEN (255)
  ) dut (
    .clk_noc   (clk_noc),
    .arst_noc  (arst_noc),
    .send      (rif),
    .start     (start),
    .dest_x    (dest_x),
    .dest_y    (dest_y),
    .vc_sel    (vc_sel),
    .pkt_len   (pkt_len),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic stall_add(input int unsigned n);
`ifdef RAVENOC_FLIT_GEN_STATS_EN
    exp_stall = exp_stall + n;
`endif
  endtask

  task automatic launch(input logic [1:0] dx, input logic [1:0] dy, input logic vc,
                        input logic [7:0] len, input logic [31:0] sd);
    dest_x = dx; dest_y = dy; vc_sel = vc; pkt_len = len; seed = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    arst_noc = 1'b1; start = 1'b0; rif.resp.ready = 2'b00;
    dest_x = '0; dest_y = '0; vc_sel = '0; pkt_len = '0; seed = '0;
    repeat (3) tick();
    checks++;
    if (rif.req.valid !== 1'b0 || rif.req.fdata !== 34'h0 || rif.req.vc_id !== 1'b0)
      $display("FAIL reset_req: valid=%b fdata=%h vc=%b, want 0/0/0", rif.req.valid, rif.req.fdata, rif.req.vc_id);
    else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 32'd0)
      $display("FAIL reset_status: busy=%b done=%b stall=%0d, want 0/0/0", busy, done, stall_cnt);
    else passed++;
    arst_noc = 1'b0;
    tick();
  endtask

  task automatic test_head_only();
    rif.resp.ready = 2'b11;
    launch(2'd1, 2'd2, 1'b0, 8'd0, 32'h0);
    checks++;
    if (rif.req.valid !== 1'b1 || rif.req.fdata !== 34'h3_6700_0000 || busy !== 1'b1)
      $display("FAIL head_only_flit: valid=%b fdata=%h busy=%b, want 1/367000000/1", rif.req.valid, rif.req.fdata, busy);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b1 || rif.req.valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL head_only_done: done=%b valid=%b busy=%b, want 1/0/0", done, rif.req.valid, busy);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b0) $display("FAIL head_only_done_pulse: done=%b, want 0", done);
    else passed++;
  endtask

  task automatic test_full_rate();
    rif.resp.ready = 2'b11;
    launch(2'd2, 2'd1, 1'b0, 8'd3, 32'h10);
    checks++;
    if (rif.req.fdata !== 34'h0_9700_0300 || rif.req.valid !== 1'b1)
      $display("FAIL full_head: fdata=%h valid=%b, want 097000300/1", rif.req.fdata, rif.req.valid);
    else passed++;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h1_0000_0010) $display("FAIL full_body0: fdata=%h, want 100000010", rif.req.fdata);
    else passed++;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h1_0000_0011) $display("FAIL full_body1: fdata=%h, want 100000011", rif.req.fdata);
    else passed++;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h2_0000_0012 || rif.req.valid !== 1'b1)
      $display("FAIL full_tail: fdata=%h valid=%b, want 200000012/1", rif.req.fdata, rif.req.valid);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL full_done: done=%b, want 1", done);
    else passed++;
    // start raised during DONE must be ignored, then accepted in the next IDLE cycle
    dest_x = 2'd1; dest_y = 2'd2; vc_sel = 1'b0; pkt_len = 8'd0; seed = 32'h0;
    start = 1'b1;
    tick();
    checks++;
    if (rif.req.valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL start_in_done: valid=%b done=%b busy=%b, want 0/0/0", rif.req.valid, done, busy);
    else passed++;
    tick();
    start = 1'b0;
    checks++;
    if (rif.req.valid !== 1'b1 || rif.req.fdata !== 34'h3_6700_0000)
      $display("FAIL start_after_done: valid=%b fdata=%h, want 1/367000000", rif.req.valid, rif.req.fdata);
    else passed++;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    rif.resp.ready = 2'b11;
    launch(2'd1, 2'd2, 1'b0, 8'd3, 32'h100);
    tick();
    checks++;
    if (rif.req.fdata !== 34'h1_0000_0100) $display("FAIL bp_body0: fdata=%h, want 100000100", rif.req.fdata);
    else passed++;
    tick();
    rif.resp.ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rif.req.fdata !== 34'h1_0000_0101 || rif.req.valid !== 1'b1 || rif.req.vc_id !== 1'b0)
        $display("FAIL bp_stable[%0d]: fdata=%h valid=%b vc=%b, want 100000101/1/0", i, rif.req.fdata, rif.req.valid, rif.req.vc_id);
      else passed++;
    end
    stall_add(5);
    checks++;
    if (stall_cnt !== exp_stall) $display("FAIL bp_stall_cnt: got %0d, want %0d", stall_cnt, exp_stall);
    else passed++;
    rif.resp.ready = 2'b11;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h2_0000_0102) $display("FAIL bp_tail: fdata=%h, want 200000102", rif.req.fdata);
    else passed++;
    repeat (2) tick();
  endtask

  task automatic test_wrong_vc();
    rif.resp.ready = 2'b01;
    launch(2'd1, 2'd2, 1'b1, 8'd0, 32'h0);
    repeat (3) tick();
    stall_add(3);
    checks++;
    if (rif.req.valid !== 1'b1 || rif.req.vc_id !== 1'b1 || rif.req.fdata !== 34'h3_6700_0000 || done !== 1'b0)
      $display("FAIL wrong_vc_hold: valid=%b vc=%b fdata=%h done=%b, want 1/1/367000000/0", rif.req.valid, rif.req.vc_id, rif.req.fdata, done);
    else passed++;
    checks++;
    if (stall_cnt !== exp_stall) $display("FAIL wrong_vc_stall: got %0d, want %0d", stall_cnt, exp_stall);
    else passed++;
    rif.resp.ready = 2'b10;
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL wrong_vc_release: done=%b, want 1", done);
    else passed++;
    tick();
  endtask

  task automatic test_wrap_reset();
    rif.resp.ready = 2'b11;
    launch(2'd1, 2'd2, 1'b0, 8'd2, 32'hFFFF_FFFF);
    checks++;
    if (rif.req.fdata !== 34'h0_6700_0200) $display("FAIL wrap_head: fdata=%h, want 067000200", rif.req.fdata);
    else passed++;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h1_FFFF_FFFF) $display("FAIL wrap_body: fdata=%h, want 1ffffffff", rif.req.fdata);
    else passed++;
    tick();
    checks++;
    if (rif.req.fdata !== 34'h2_0000_0000) $display("FAIL wrap_tail: fdata=%h, want 200000000", rif.req.fdata);
    else passed++;
    repeat (2) tick();
    launch(2'd1, 2'd2, 1'b0, 8'd2, 32'hFFFF_FFFF);
    arst_noc = 1'b1;
    start = 1'b1;
    tick();
    exp_stall = 0;
    checks++;
    if (rif.req.valid !== 1'b0 || rif.req.fdata !== 34'h0 || busy !== 1'b0 || stall_cnt !== exp_stall)
      $display("FAIL mid_reset: valid=%b fdata=%h busy=%b stall=%0d, want 0/0/0/0", rif.req.valid, rif.req.fdata, busy, stall_cnt);
    else passed++;
    tick();
    arst_noc = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (rif.req.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL post_reset_idle: valid=%b busy=%b done=%b, want 0/0/0", rif.req.valid, busy, done);
    else passed++;
  endtask

  task automatic test_start_busy();
    int unsigned flits = 0;
    int unsigned dones = 0;
    rif.resp.ready = 2'b11;
    launch(2'd2, 2'd1, 1'b0, 8'd2, 32'h20);
    for (int c = 0; c < 8; c++) begin
      if (rif.req.valid === 1'b1) flits++;
      if (done === 1'b1) dones++;
      if (c == 1) begin
        checks++;
        if (rif.req.fdata !== 34'h1_0000_0020) $display("FAIL busy_body0: fdata=%h, want 100000020", rif.req.fdata);
        else passed++;
      end
      if (c == 2) begin
        checks++;
        if (rif.req.fdata !== 34'h2_0000_0021) $display("FAIL busy_tail: fdata=%h, want 200000021", rif.req.fdata);
        else passed++;
      end
      if (c == 1) begin
        dest_x = 2'd1; dest_y = 2'd2; pkt_len = 8'd0; seed = 32'h55;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checks++;
    if (flits != 3 || dones != 1)
      $display("FAIL start_while_busy: flits=%0d dones=%0d, want 3/1", flits, dones);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_head_only();
    test_full_rate();
    test_backpressure();
    test_wrong_vc();
    test_wrap_reset();
    test_start_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ravenoc_flit_gen.md
RAVENOC_FLIT_GEN -- requirements
Module: ravenoc_flit_gen

Interface
REQ-001 Parameter ROUTER_X_ID, default 0: source row id inserted in head flits.
REQ-002 Parameter ROUTER_Y_ID, default 0: source column id inserted in head flits.
REQ-003 Parameter MAX_PKT_LEN, default 255: maximum body-flit count; sets the pkt_len width as clog2(MAX_PKT_LEN+1).
REQ-004 clk_noc  input  1: NoC clock; single clock domain.
REQ-005 arst_noc  input  1: reset, synchronous and active-high.
REQ-006 send  router_if.send_flit: drives send.req (fdata, vc_id, valid); samples send.resp.ready[vc].
REQ-007 start  input  1: one-cycle pulse; launches one packet with the currently sampled fields.
REQ-008 dest_x / dest_y  input  X_WIDTH / Y_WIDTH: destination coordinates.
REQ-009 vc_sel  input  VC_WIDTH: virtual channel used for the whole packet.
REQ-010 pkt_len  input  clog2(MAX_PKT_LEN+1): number of body flits after the head, range 0..MAX_PKT_LEN.
REQ-011 seed  input  32: first body payload value.
REQ-012 busy  output  1: high from start acceptance until the last flit is accepted.
REQ-013 done  output  1: one-cycle pulse after the last flit is accepted.
REQ-014 stall_cnt  output  32: cycles with valid=1 and ready=0 (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, HEAD, BODY and DONE.
REQ-016 IDLE: start=1 latches dest_x, dest_y, vc_sel, pkt_len and seed, then moves to HEAD next cycle; start while busy SHALL be ignored.
REQ-017 HEAD: valid=1; fdata SHALL hold the head type, dest_x/dest_y, ROUTER_X_ID/ROUTER_Y_ID and the latched pkt_len.
REQ-018 A flit SHALL transfer only in a cycle where valid=1 and send.resp.ready[vc_sel]=1; ready on other VCs has no effect.
REQ-019 While valid=1 and ready=0, fdata, vc_id and valid SHALL stay stable.
REQ-020 HEAD accepted with latched pkt_len=0: the head SHALL carry the HEAD_TAIL type and the FSM goes to DONE; otherwise the FSM goes to BODY.
REQ-021 BODY: payload SHALL be seed+k for flit k, k = 0..pkt_len-1, with 32-bit wrap-around.
REQ-022 BODY flit type SHALL be BODY for k < pkt_len-1 and TAIL for k = pkt_len-1.
REQ-023 BODY: after the TAIL is accepted, the FSM SHALL go to DONE.
REQ-024 DONE: done=1 and valid=0 for exactly one cycle, then IDLE.
REQ-025 Minimum latency: start to head valid = 1 cycle; back-to-back flits SHALL transfer on consecutive cycles when ready is held at 1.
REQ-026 A start in the DONE cycle SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-027 arst_noc=1 at a clock edge SHALL force IDLE, valid=0, vc_id=0, fdata=0, busy=0, done=0 and stall_cnt=0.
REQ-028 Reset mid-packet SHALL abandon the packet without emitting a tail; start SHALL be ignored during reset.

Configuration
REQ-029 Macro RAVENOC_FLIT_GEN_STATS_EN defined: stall_cnt increments each cycle with valid=1 and ready[vc_sel]=0, saturates at 2^32-1, and clears only on reset.
REQ-030 RAVENOC_FLIT_GEN_STATS_EN undefined: stall_cnt SHALL be a constant 0 and the counter logic SHALL be absent.

Structure
REQ-031 The flit-type enum (HEAD, BODY, TAIL, HEAD_TAIL), the head-flit field packing, X_WIDTH, Y_WIDTH, VC_WIDTH and FLIT_WIDTH SHALL live in ravenoc_pkg.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 The module SHALL be a single module with no sub-module.

Verification
REQ-034 Head-only packet: dest=(1,2), pkt_len=0, ready=1 -> one HEAD_TAIL flit 1 cycle after start; done 1 cycle after acceptance.
REQ-035 Full-rate packet: pkt_len=3, seed=0x10, ready=1 -> head, BODY 0x10, BODY 0x11, TAIL 0x12 on 4 consecutive cycles.
REQ-036 Backpressure: ready[vc]=0 for 5 cycles during the second body flit -> fdata stable throughout; stall_cnt=5 with STATS_EN.
REQ-037 Wrong-VC ready: vc_sel=1, only ready[0]=1 -> no transfer; valid held; stall_cnt counts.
REQ-038 Wrap and reset: seed=0xFFFFFFFF, pkt_len=2 -> payloads 0xFFFFFFFF then 0x0; assert arst_noc after the head -> valid=0 next cycle and the FSM returns to IDLE.
REQ-039 Start while busy: second start pulse mid-packet -> ignored; exactly one packet emitted.
